// File: rtl/spi_engine_arbiter.sv
// spi_engine_arbiter
//   Shares one SPI_MODULE word-transfer engine (GO/DONE handshake) between
//   N_REQ requesters. Round-robin grant, 4-phase engine handshake, one-cycle
//   ACK back to the granted requester with the received word on RD_DATA.
//
// Parameters
//   N_REQ          number of requesters (2..8)
//   DATA_W         transfer word width, matches SPI_IN/SPI_OUT
//   TIMEOUT_CYCLES watchdog limit in CLOCK cycles (timeout build only)
//
// Ports
//   CLOCK, RESET_N   clock, synchronous active-low reset
//   REQ              per-requester request level
//   REQ_DATA         per-requester tx word, requester i at [i*DATA_W +: DATA_W]
//   ACK              one-cycle completion pulse to the granted requester
//   RD_DATA          received word, valid with ACK, held until next ACK
//   ERR              pulses with ACK when the transfer timed out
//   BUSY             high from grant until the engine has released DONE
//   GNT_IDX          current / last granted requester
//   ENG_GO, ENG_IN   to SPI_MODULE GO / SPI_IN
//   ENG_OUT, ENG_DONE from SPI_MODULE SPI_OUT / DONE
//
// Build option
//   SPI_ARB_TIMEOUT_EN  enables the BUSY-state watchdog; when undefined ERR
//                       is tied low and BUSY waits for DONE indefinitely.
module spi_engine_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     CLOCK,
  input  logic                     RESET_N,
  input  logic [N_REQ-1:0]         REQ,
  input  logic [N_REQ*DATA_W-1:0]  REQ_DATA,
  output logic [N_REQ-1:0]         ACK,
  output logic [DATA_W-1:0]        RD_DATA,
  output logic                     ERR,
  output logic                     BUSY,
  output logic [$clog2(N_REQ)-1:0] GNT_IDX,
  output logic                     ENG_GO,
  output logic [DATA_W-1:0]        ENG_IN,
  input  logic [DATA_W-1:0]        ENG_OUT,
  input  logic                     ENG_DONE
);

  localparam int IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_param
    $error("spi_engine_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

  state_t                        state, state_nxt;
  logic [IDX_W-1:0]              ptr, ptr_nxt, ptr_inc;
  logic [IDX_W-1:0]              gnt_nxt;
  logic [N_REQ-1:0]              ack_nxt;
  logic                          go_nxt, busy_nxt;
  logic [DATA_W-1:0]             eng_in_nxt, rd_nxt;
  logic [N_REQ-1:0][DATA_W-1:0]  req_word;

  assign req_word = REQ_DATA;

  // ---------------------------------------------------------------------
  // Round-robin pick: lowest set bit at or above ptr wins, otherwise wrap
  // to the lowest set bit overall.
  // ---------------------------------------------------------------------
  logic             hi_vld;
  logic [IDX_W-1:0] hi_idx, lo_idx, pick_idx;

  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (REQ[i]) begin
        lo_idx = IDX_W'(i);
        if (IDX_W'(i) >= ptr) begin
          hi_vld = 1'b1;
          hi_idx = IDX_W'(i);
        end
      end
    end
    pick_idx = hi_vld ? hi_idx : lo_idx;
  end

  assign ptr_inc = (GNT_IDX == IDX_W'(N_REQ-1)) ? '0 : GNT_IDX + 1'b1;

  // ---------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------
`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        timeout;
  logic        err_nxt;

  assign timeout = (to_cnt == 16'(TIMEOUT_CYCLES-1));

  // Cleared whenever idle, so it always starts from zero at grant.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N)             to_cnt <= '0;
    else if (state == S_BUSY) to_cnt <= to_cnt + 16'd1;
    else                      to_cnt <= '0;
  end
`else
  assign ERR = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Next-state / next-output
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    gnt_nxt    = GNT_IDX;
    ack_nxt    = '0;
    go_nxt     = ENG_GO;
    busy_nxt   = BUSY;
    eng_in_nxt = ENG_IN;
    rd_nxt     = RD_DATA;
`ifdef SPI_ARB_TIMEOUT_EN
    err_nxt    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        // DONE still high means the engine has not finished its return
        // phase; granting now would break the 4-phase handshake.
        if (|REQ && !ENG_DONE) begin
          gnt_nxt    = pick_idx;
          eng_in_nxt = req_word[pick_idx];
          go_nxt     = 1'b1;
          busy_nxt   = 1'b1;
          state_nxt  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (ENG_DONE) begin
          rd_nxt           = ENG_OUT;
          ack_nxt[GNT_IDX] = 1'b1;
          go_nxt           = 1'b0;
          ptr_nxt          = ptr_inc;
          state_nxt        = S_RELEASE;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (timeout) begin
          rd_nxt           = '0;
          ack_nxt[GNT_IDX] = 1'b1;
          err_nxt          = 1'b1;
          go_nxt           = 1'b0;
          ptr_nxt          = ptr_inc;
          state_nxt        = S_RELEASE;
        end
`endif
      end
      S_RELEASE: begin
        if (!ENG_DONE) begin
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers (all outputs are registered)
  // ---------------------------------------------------------------------
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state   <= S_IDLE;
      ptr     <= '0;
      GNT_IDX <= '0;
      ACK     <= '0;
      ENG_GO  <= 1'b0;
      BUSY    <= 1'b0;
      ENG_IN  <= '0;
      RD_DATA <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      GNT_IDX <= gnt_nxt;
      ACK     <= ack_nxt;
      ENG_GO  <= go_nxt;
      BUSY    <= busy_nxt;
      ENG_IN  <= eng_in_nxt;
      RD_DATA <= rd_nxt;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) ERR <= 1'b0;
    else          ERR <= err_nxt;
  end
`endif

endmodule

// File: tb/tb_spi_engine_arbiter.sv
// Directed bench for spi_engine_arbiter (N_REQ=4, DATA_W=32, TIMEOUT_CYCLES=64)
// with a behavioural SPI engine: DONE rises done_dly cycles after GO, stays
// high hold_dly cycles after GO drops, and returns ENG_IN ^ resp_xor.
module tb_spi_engine_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  ack;
  logic [DW-1:0] rd_data;
  logic          err, busy;
  logic [1:0]    gnt_idx;
  logic          eng_go;
  logic [DW-1:0] eng_in;
  logic [DW-1:0] eng_out = '0;
  logic          eng_done = 1'b0;

  int            done_dly, hold_dly;
  logic          never;
  logic [DW-1:0] resp_xor;
  int            go_cnt = 0, rel_cnt = 0;

  int n_tests = 0, n_fail = 0;
  int cyc;

  always #5 clk = ~clk;

  spi_engine_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT_CYCLES(64)) dut (
    .CLOCK(clk), .RESET_N(rst_n), .REQ(req), .REQ_DATA(req_data),
    .ACK(ack), .RD_DATA(rd_data), .ERR(err), .BUSY(busy), .GNT_IDX(gnt_idx),
    .ENG_GO(eng_go), .ENG_IN(eng_in), .ENG_OUT(eng_out), .ENG_DONE(eng_done)
  );

  // engine model
  always @(posedge clk) begin
    if (eng_go && !eng_done) begin
      go_cnt <= go_cnt + 1;
      if (!never && go_cnt == done_dly-1) begin
        eng_done <= 1'b1;
        eng_out  <= eng_in ^ resp_xor;
      end
    end else if (!eng_go) begin
      go_cnt <= 0;
    end
    if (!eng_go && eng_done) begin
      rel_cnt <= rel_cnt + 1;
      if (rel_cnt >= hold_dly) begin
        eng_done <= 1'b0;
        rel_cnt  <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input int max_cyc, output int c);
    c = 0;
    while (ack == '0 && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    chk("ack_seen", {63'd0, |ack}, 64'd1);
  endtask

  task automatic wait_idle(input int max_cyc);
    int c;
    c = 0;
    while (busy && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    chk("idle_reached", {63'd0, busy}, 64'd0);
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [DW-1:0] words [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  logic [DW-1:0] rd_exp [4] = '{32'h1E1E1E1E, 32'h2D2D2D2D, 32'h3C3C3C3C, 32'h4B4B4B4B};
  int            order [5] = '{0, 1, 2, 3, 0};

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int d, r, n, viol;
    logic seen;
    rst_n = 1'b0; req = '0; req_data = '0;
    done_dly = 40; hold_dly = 0; never = 1'b0; resp_xor = 32'hB89EFCD6;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_ack",  ack,     0);
    chk("rst_err",  err,     0);
    chk("rst_busy", busy,    0);
    chk("rst_go",   eng_go,  0);
    chk("rst_in",   eng_in,  0);
    chk("rst_rd",   rd_data, 0);
    chk("rst_gnt",  gnt_idx, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_noreq_busy", busy, 0);

    // single request
    req_data[31:0] = 32'hAAAAAAAE;
    req = 4'b0001;
    @(negedge clk);
    chk("t1_go",   eng_go, 1);
    chk("t1_in",   eng_in, 32'hAAAAAAAE);
    chk("t1_busy", busy, 1);
    chk("t1_gnt",  gnt_idx, 0);
    wait_ack(100, cyc);
    chk("t1_lat",  cyc, 41);
    chk("t1_ack",  ack, 4'b0001);
    chk("t1_rd",   rd_data, 32'h12345678);
    chk("t1_err",  err, 0);
    chk("t1_go_low", eng_go, 0);
    req = '0;
    @(negedge clk);
    chk("t1_ack_1cyc", ack, 0);
    chk("t1_rd_hold", rd_data, 32'h12345678);
    wait_idle(20);

    // contention, round-robin order 0,1,2,3,0
    rst_pulse();
    done_dly = 3; resp_xor = 32'h0F0F0F0F;
    for (int i = 0; i < 4; i++) req_data[i*DW +: DW] = words[i];
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(50, cyc);
      chk("rr_ack", ack, 4'b0001 << order[k]);
      chk("rr_gnt", gnt_idx, order[k]);
      chk("rr_in",  eng_in, words[order[k]]);
      chk("rr_rd",  rd_data, rd_exp[order[k]]);
      @(negedge clk);
    end
    req = '0;
    wait_idle(40);

    // handshake: DONE held 5 cycles after GO drops, second request pending
    rst_pulse();
    done_dly = 4; hold_dly = 5;
    req = 4'b0011;
    wait_ack(50, cyc);
    chk("hs_ack0", ack, 4'b0001);
    d = -1; r = -1; n = 0; viol = 0;
    while (r < 0 && n < 60) begin
      @(negedge clk);
      n++;
      if (eng_go && eng_done) viol++;
      if (d < 0 && !eng_done) d = n;
      if (d >= 0 && eng_go && r < 0) r = n;
    end
    chk("hs_gap",  r - d, 2);
    chk("hs_viol", viol, 0);
    chk("hs_gnt",  gnt_idx, 1);
    wait_ack(50, cyc);
    chk("hs_ack1", ack, 4'b0010);
    req = '0;
    @(negedge clk);
    wait_idle(40);

    // reset mid-transfer (ptr is 2 before reset)
    hold_dly = 0; done_dly = 20;
    req = 4'b0010;
    @(negedge clk);
    chk("mr_gnt", gnt_idx, 1);
    chk("mr_go",  eng_go, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0; req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mr_go0",   eng_go, 0);
    chk("mr_busy0", busy, 0);
    chk("mr_ack0",  ack, 0);
    chk("mr_gnt0",  gnt_idx, 0);
    req = 4'b0101;
    @(negedge clk);
    chk("mr_ptr_gnt", gnt_idx, 0);
    chk("mr_go1", eng_go, 1);
    wait_ack(50, cyc);
    chk("mr_ack", ack, 4'b0001);
    req = '0;
    @(negedge clk);
    wait_idle(20);

    // data stability: requester word changes after grant
    done_dly = 10; resp_xor = 32'h0F0F0F0F;
    req_data[2*DW +: DW] = 32'hCAFEF00D;
    req = 4'b0100;
    @(negedge clk);
    chk("ds_in0", eng_in, 32'hCAFEF00D);
    repeat (3) @(negedge clk);
    req_data[2*DW +: DW] = 32'h0BADBEEF;
    @(negedge clk);
    chk("ds_in_mid", eng_in, 32'hCAFEF00D);
    wait_ack(50, cyc);
    chk("ds_ack", ack, 4'b0100);
    chk("ds_in_ack", eng_in, 32'hCAFEF00D);
    chk("ds_rd", rd_data, 32'hC5F1FF02);
    req = '0;
    @(negedge clk);
    wait_idle(20);

    // engine never answers
    never = 1'b1;
    req = 4'b1000;
    @(negedge clk);
    chk("to_go", eng_go, 1);
`ifdef SPI_ARB_TIMEOUT_EN
    wait_ack(200, cyc);
    chk("to_lat", cyc, 64);
    chk("to_ack", ack, 4'b1000);
    chk("to_err", err, 1);
    chk("to_rd",  rd_data, 0);
    chk("to_go0", eng_go, 0);
    req = '0;
    @(negedge clk);
    chk("to_err_1cyc", err, 0);
    wait_idle(20);
`else
    seen = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (ack != '0 || err) seen = 1'b1;
    end
    chk("nto_busy", busy, 1);
    chk("nto_go",   eng_go, 1);
    chk("nto_noack", seen, 0);
    req = '0;
    rst_pulse();
`endif
    never = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
